// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution at EX with a bimodal predictor at IF.
// Ports: if_pc->pred_taken (comb); ex_* in -> jump_op/flush/link_we (reg), stat_br/stat_miss.
module branch_resolve_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = 4,
  parameter int PRED_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic              ex_jump,
  input  logic [1:0]        ex_jump_type,
  input  logic              ex_bne,
  input  logic              ex_zero,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pc,
  output logic [2:0]        jump_op,
  output logic              flush,
  output logic              link_we,
  output logic [CNT_W-1:0]  stat_br,
  output logic [CNT_W-1:0]  stat_miss
);

  localparam int N = 1 << IDX_W;

  localparam logic [2:0] OP_SEQ = 3'b000;
  localparam logic [2:0] OP_BR  = 3'b001;
  localparam logic [2:0] OP_REG = 3'b010;
  localparam logic [2:0] OP_JMP = 3'b011;
  localparam logic [2:0] OP_REC = 3'b100;

  localparam logic [1:0] T_JR = 2'b00;
  localparam logic [1:0] T_BR = 2'b01;
  localparam logic [1:0] T_J  = 2'b10;
  localparam logic [1:0] T_JAL = 2'b11;

  logic [1:0]       tbl_q [N];
  logic [1:0]       tbl_d [N];
  logic [2:0]       jump_op_q, jump_op_d;
  logic             flush_q, flush_d;
  logic             link_we_q, link_we_d;
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_miss_q, stat_miss_d;

  logic             ev;
  logic             br_ev;
  logic             taken;
  logic             miss;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Reads the registered table only: a same-cycle update is not bypassed.
  assign pred_taken = (PRED_EN != 0) & tbl_q[if_idx][1];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[ADDR_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[ADDR_W-1:IDX_W+2], ex_pc[1:0]};

  always_comb begin
    ev    = ex_valid & ~ex_stall & ex_jump;
    br_ev = ev & (ex_jump_type == T_BR);
    // Only conditional branches can fall through.
    taken = (ex_jump_type != T_BR) | (ex_zero ^ ex_bne);
    miss  = br_ev & (taken ^ ex_pred_taken);

    jump_op_d = OP_SEQ;
    flush_d   = 1'b0;
    link_we_d = 1'b0;
    if (ev) begin
      case (ex_jump_type)
        T_JR: begin
          jump_op_d = OP_REG;
          flush_d   = 1'b1;
        end
        T_J: begin
          jump_op_d = OP_JMP;
          flush_d   = 1'b1;
        end
        T_JAL: begin
          jump_op_d = OP_JMP;
          flush_d   = 1'b1;
          link_we_d = 1'b1;
        end
        default: begin
          // Correct prediction: front end is already on the right path.
          if (taken & ~ex_pred_taken) begin
            jump_op_d = OP_BR;
            flush_d   = 1'b1;
          end else if (~taken & ex_pred_taken) begin
            jump_op_d = OP_REC;
            flush_d   = 1'b1;
          end
        end
      endcase
    end

    stat_br_d = stat_br_q;
    if (br_ev && stat_br_q != '1)
      stat_br_d = stat_br_q + CNT_W'(1);

    stat_miss_d = stat_miss_q;
    if (miss && stat_miss_q != '1)
      stat_miss_d = stat_miss_q + CNT_W'(1);

    tbl_d = tbl_q;
    if (PRED_EN != 0 && br_ev) begin
      if (taken && tbl_q[ex_idx] != 2'b11)
        tbl_d[ex_idx] = tbl_q[ex_idx] + 2'b01;
      else if (!taken && tbl_q[ex_idx] != 2'b00)
        tbl_d[ex_idx] = tbl_q[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        tbl_q[i] <= 2'b01;
      jump_op_q   <= OP_SEQ;
      flush_q     <= 1'b0;
      link_we_q   <= 1'b0;
      stat_br_q   <= '0;
      stat_miss_q <= '0;
    end else begin
      tbl_q       <= tbl_d;
      jump_op_q   <= jump_op_d;
      flush_q     <= flush_d;
      link_we_q   <= link_we_d;
      stat_br_q   <= stat_br_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign jump_op   = jump_op_q;
  assign flush     = flush_q;
  assign link_we   = link_we_q;
  assign stat_br   = stat_br_q;
  assign stat_miss = stat_miss_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: queue-based scoreboard plus per-feature tasks.
// Second instance runs static mode with 4-bit statistics on the same stimulus.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid, ex_stall, ex_jump;
  logic [1:0]  ex_jump_type;
  logic        ex_bne, ex_zero, ex_pred_taken;
  logic [31:0] ex_pc;

  logic        pred_taken, flush, link_we;
  logic [2:0]  jump_op;
  logic [15:0] stat_br, stat_miss;

  logic        s_pred, s_flush, s_link_we;
  logic [2:0]  s_jump_op;
  logic [3:0]  s_stat_br, s_stat_miss;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .ADDR_W(32), .IDX_W(4), .PRED_EN(1), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_jump(ex_jump),
    .ex_jump_type(ex_jump_type), .ex_bne(ex_bne), .ex_zero(ex_zero),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
    .jump_op(jump_op), .flush(flush), .link_we(link_we),
    .stat_br(stat_br), .stat_miss(stat_miss)
  );

  branch_resolve_ctrl #(
    .ADDR_W(32), .IDX_W(4), .PRED_EN(0), .CNT_W(4)
  ) u_static (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(s_pred),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_jump(ex_jump),
    .ex_jump_type(ex_jump_type), .ex_bne(ex_bne), .ex_zero(ex_zero),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
    .jump_op(s_jump_op), .flush(s_flush), .link_we(s_link_we),
    .stat_br(s_stat_br), .stat_miss(s_stat_miss)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic        fl;
    logic        lw;
    logic [15:0] br;
    logic [15:0] miss;
    logic [3:0]  br4;
    logic [3:0]  miss4;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [1:0] mtbl [16];
  int   mbr, mmiss;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mtbl[i] = 2'b01;
    mbr = 0;
    mmiss = 0;
  endtask

  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_tests++;
      if ({jump_op, flush, link_we} !== {mon_e.op, mon_e.fl, mon_e.lw}) begin
        n_fail++;
        $display("FAIL sb_out got op=%b fl=%b lw=%b exp op=%b fl=%b lw=%b",
                 jump_op, flush, link_we, mon_e.op, mon_e.fl, mon_e.lw);
      end
      n_tests++;
      if (stat_br !== mon_e.br || stat_miss !== mon_e.miss) begin
        n_fail++;
        $display("FAIL sb_stat got br=%0d miss=%0d exp br=%0d miss=%0d",
                 stat_br, stat_miss, mon_e.br, mon_e.miss);
      end
      n_tests++;
      if ({s_jump_op, s_flush, s_link_we, s_stat_br, s_stat_miss} !==
          {mon_e.op, mon_e.fl, mon_e.lw, mon_e.br4, mon_e.miss4}) begin
        n_fail++;
        $display("FAIL sb_static got op=%b fl=%b br=%0d miss=%0d exp op=%b fl=%b br=%0d miss=%0d",
                 s_jump_op, s_flush, s_stat_br, s_stat_miss,
                 mon_e.op, mon_e.fl, mon_e.br4, mon_e.miss4);
      end
    end
  end

  task automatic drv_set(input logic v, input logic st, input logic j,
                         input logic [1:0] t, input logic bne,
                         input logic z, input logic pt,
                         input logic [31:0] pc);
    exp_t e;
    logic tk;
    int   ix;
    @(negedge clk);
    ex_valid = v; ex_stall = st; ex_jump = j; ex_jump_type = t;
    ex_bne = bne; ex_zero = z; ex_pred_taken = pt; ex_pc = pc;
    e = '0;
    if (v && !st && j) begin
      case (t)
        2'b00: begin e.op = 3'b010; e.fl = 1'b1; end
        2'b10: begin e.op = 3'b011; e.fl = 1'b1; end
        2'b11: begin e.op = 3'b011; e.fl = 1'b1; e.lw = 1'b1; end
        default: begin
          tk = z ^ bne;
          ix = int'(pc[5:2]);
          mbr++;
          if (tk != pt) mmiss++;
          if (tk && !pt) begin e.op = 3'b001; e.fl = 1'b1; end
          if (!tk && pt) begin e.op = 3'b100; e.fl = 1'b1; end
          if (tk && mtbl[ix] != 2'b11) mtbl[ix] = mtbl[ix] + 2'b01;
          else if (!tk && mtbl[ix] != 2'b00) mtbl[ix] = mtbl[ix] - 2'b01;
        end
      endcase
    end
    e.br    = 16'(sat(mbr, 65535));
    e.miss  = 16'(sat(mmiss, 65535));
    e.br4   = 4'(sat(mbr, 15));
    e.miss4 = 4'(sat(mmiss, 15));
    q.push_back(e);
  endtask

  task automatic drv_fin();
    @(posedge clk);
    #3;
  endtask

  task automatic drv(input logic v, input logic st, input logic j,
                     input logic [1:0] t, input logic bne,
                     input logic z, input logic pt,
                     input logic [31:0] pc);
    drv_set(v, st, j, t, bne, z, pt, pc);
    drv_fin();
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_pc = '0;
    ex_valid = 0; ex_stall = 0; ex_jump = 0; ex_jump_type = 2'b00;
    ex_bne = 0; ex_zero = 0; ex_pred_taken = 0; ex_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    n_tests++;
    if ({jump_op, flush, link_we, stat_br, stat_miss} !== '0) begin
      n_fail++;
      $display("FAIL reset_out got op=%b fl=%b lw=%b br=%0d miss=%0d exp all 0",
               jump_op, flush, link_we, stat_br, stat_miss);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      n_tests++;
      if (pred_taken !== 1'b0 || s_pred !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_pred idx=%0d got=%b/%b exp=0", i, pred_taken, s_pred);
      end
    end
  endtask

  task automatic test_beq_learn();
    drv(1, 0, 1, 2'b01, 0, 1, 0, 32'h40);
    if_pc = 32'h40;
    #1;
    n_tests++;
    if (jump_op !== 3'b001 || flush !== 1'b1 || pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_first got op=%b fl=%b pred=%b exp op=001 fl=1 pred=1",
               jump_op, flush, pred_taken);
    end
    drv(1, 0, 1, 2'b01, 0, 1, 1, 32'h40);
    n_tests++;
    if (jump_op !== 3'b000 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_second got op=%b fl=%b exp op=000 fl=0", jump_op, flush);
    end
    drv(1, 0, 1, 2'b01, 0, 1, 1, 32'h40);
    drv(1, 0, 1, 2'b01, 1, 1, 1, 32'h40);
    n_tests++;
    if (jump_op !== 3'b100 || flush !== 1'b1 || pred_taken !== 1'b1 ||
        stat_miss !== 16'd2 || stat_br !== 16'd4) begin
      n_fail++;
      $display("FAIL bne_miss got op=%b fl=%b pred=%b miss=%0d br=%0d exp op=100 fl=1 pred=1 miss=2 br=4",
               jump_op, flush, pred_taken, stat_miss, stat_br);
    end
    drv(1, 0, 1, 2'b01, 1, 1, 1, 32'h40);
    n_tests++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_check got pred=%b exp=0", pred_taken);
    end
    drv_set(1, 0, 1, 2'b01, 0, 1, 0, 32'h40);
    #1;
    n_tests++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass got pred=%b exp=0", pred_taken);
    end
    drv_fin();
    n_tests++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL post_write got pred=%b exp=1", pred_taken);
    end
    idle();
  endtask

  task automatic test_jumps();
    drv(1, 0, 1, 2'b00, 0, 0, 0, 32'h100);
    n_tests++;
    if (jump_op !== 3'b010 || flush !== 1'b1 || link_we !== 1'b0) begin
      n_fail++;
      $display("FAIL jr got op=%b fl=%b lw=%b exp 010 1 0", jump_op, flush, link_we);
    end
    drv(1, 0, 1, 2'b11, 0, 0, 0, 32'h104);
    n_tests++;
    if (jump_op !== 3'b011 || flush !== 1'b1 || link_we !== 1'b1) begin
      n_fail++;
      $display("FAIL jal got op=%b fl=%b lw=%b exp 011 1 1", jump_op, flush, link_we);
    end
    drv(1, 0, 1, 2'b10, 0, 0, 0, 32'h108);
    drv(0, 0, 1, 2'b00, 0, 0, 0, 32'h10C);
    drv(1, 0, 0, 2'b11, 0, 0, 0, 32'h110);
    n_tests++;
    if (stat_br !== 16'd6 || flush !== 1'b0 || link_we !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_stats got br=%0d fl=%b lw=%b exp br=6 fl=0 lw=0",
               stat_br, flush, link_we);
    end
    idle();
  endtask

  task automatic test_stall();
    if_pc = 32'h0C;
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 1, 2'b01, 0, 1, 0, 32'h0C);
      n_tests++;
      if (flush !== 1'b0 || stat_br !== 16'd6 || pred_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold got fl=%b br=%0d pred=%b exp fl=0 br=6 pred=0",
                 flush, stat_br, pred_taken);
      end
    end
    drv(1, 0, 1, 2'b01, 0, 1, 0, 32'h0C);
    n_tests++;
    if (jump_op !== 3'b001 || flush !== 1'b1 || stat_br !== 16'd7 ||
        pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release got op=%b fl=%b br=%0d pred=%b exp 001 1 7 1",
               jump_op, flush, stat_br, pred_taken);
    end
    idle();
    n_tests++;
    if (flush !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_pulse got fl=%b exp=0", flush);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rst = 1'b1;
    ex_valid = 1; ex_stall = 0; ex_jump = 1; ex_jump_type = 2'b00;
    @(posedge clk);
    #3;
    n_tests++;
    if ({jump_op, flush, link_we, stat_br, stat_miss} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset got op=%b fl=%b br=%0d miss=%0d exp all 0",
               jump_op, flush, stat_br, stat_miss);
    end
    @(negedge clk);
    rst = 1'b0;
    ex_valid = 0; ex_jump = 0;
    model_reset();
    if_pc = 32'h0C;
    #1;
    n_tests++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_tbl got pred=%b exp=0", pred_taken);
    end
  endtask

  task automatic test_sat_static();
    for (int i = 0; i < 20; i++)
      drv(1, 0, 1, 2'b01, 0, 1, 0, 32'h08);
    idle();
    n_tests++;
    if (s_stat_miss !== 4'd15 || s_stat_br !== 4'd15 || stat_miss !== 16'd20) begin
      n_fail++;
      $display("FAIL stat_sat got s_miss=%0d s_br=%0d miss=%0d exp 15 15 20",
               s_stat_miss, s_stat_br, stat_miss);
    end
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      n_tests++;
      if (s_pred !== 1'b0 || pred_taken !== mtbl[i][1]) begin
        n_fail++;
        $display("FAIL pred_scan idx=%0d got=%b/%b exp=0/%b",
                 i, s_pred, pred_taken, mtbl[i][1]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_beq_learn();
    test_jumps();
    test_stall();
    test_mid_reset();
    test_sat_static();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
